// File: rtl/fir_output_formatter.sv
// FIR output formatter: round/shift the full-precision FIR result, saturate to
// the output width, decimate, and buffer in a small FWFT FIFO with debug counters.
module fir_output_formatter #(
    parameter int InputWidth  = 38,
    parameter int OutputWidth = 16,
    parameter int Shift       = 20,
    parameter int FifoDepth   = 4,
    parameter int DecimWidth  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [InputWidth-1:0]  dataIn,
    input  logic [DecimWidth-1:0]  decimFactor,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [OutputWidth-1:0] dataOut,
    output logic                   fifoFull,
    output logic [15:0]            satCount,
    output logic [15:0]            dropCount
);

    localparam int PtrW   = $clog2(FifoDepth);
    localparam int CntW   = $clog2(FifoDepth + 1);
    localparam int RShift = (Shift > 0) ? Shift - 1 : 0;

    localparam logic [InputWidth:0] RoundAdd =
        (Shift > 0) ? ((InputWidth + 1)'(1) << RShift) : '0;
    localparam logic signed [InputWidth:0] SatMax =
        (InputWidth + 1)'((1 << (OutputWidth - 1)) - 1);
    localparam logic signed [InputWidth:0] SatMin = ~SatMax;
    localparam logic [OutputWidth-1:0] MaxOut = {1'b0, {(OutputWidth-1){1'b1}}};
    localparam logic [OutputWidth-1:0] MinOut = {1'b1, {(OutputWidth-1){1'b0}}};

    // ---------------- stage 1: round half up, arithmetic shift ----------------
    logic [InputWidth:0]        ext_in;
    logic [InputWidth:0]        rnd_sum;
    logic signed [InputWidth:0] rnd;
    logic signed [InputWidth:0] s1_r;
    logic                       s1_valid;

    // One extra bit keeps the rounding add from overflowing at the positive limit.
    assign ext_in  = {dataIn[InputWidth-1], dataIn};
    assign rnd_sum = ext_in + RoundAdd;
    assign rnd     = $signed(rnd_sum) >>> Shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= inValid;
            if (inValid) s1_r <= rnd;
        end
    end

    // ---------------- stage 2: saturate, decimate ----------------
    logic [OutputWidth-1:0] sat_val;
    logic                   clipped;
    logic [DecimWidth-1:0]  phase;
    logic [DecimWidth-1:0]  eff_m1;
    logic                   keep;
    logic                   push;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    always_comb begin
        sat_val = s1_r[OutputWidth-1:0];
        clipped = 1'b0;
        if (s1_r > SatMax) begin
            sat_val = MaxOut;
            clipped = 1'b1;
        end else if (s1_r < SatMin) begin
            sat_val = MinOut;
            clipped = 1'b1;
        end
    end

    assign eff_m1 = (decimFactor == '0) ? '0 : decimFactor - 1'b1;
    assign keep   = (phase == '0);
    assign push   = s1_valid && keep;
    assign pop    = outValid && outReady;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_en  = push && (!fifoFull || pop);
    assign drop   = push && fifoFull && !pop;

    // ">=" rather than "==" so a lowered factor mid-run cannot strand the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (s1_valid) begin
            phase <= (phase >= eff_m1) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            satCount  <= '0;
            dropCount <= '0;
        end else begin
            if (push && clipped && satCount != 16'hFFFF) satCount <= satCount + 16'd1;
            if (drop && dropCount != 16'hFFFF)           dropCount <= dropCount + 16'd1;
        end
    end

    // ---------------- output FIFO ----------------
    logic [OutputWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]        wr_ptr;
    logic [PtrW-1:0]        rd_ptr;
    logic [CntW-1:0]        count;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sat_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign outValid = (count != '0);
    assign fifoFull = (count == CntW'(FifoDepth));
    assign dataOut  = outValid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_output_formatter.sv
// Directed bench for fir_output_formatter: rounding/saturation table plus
// decimation, backpressure, full-with-pop and async-reset sequences.
module tb_fir_output_formatter;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [37:0] dataIn;
    logic [3:0]  decimFactor;
    logic        outValid;
    logic        outReady;
    logic [15:0] dataOut;
    logic        fifoFull;
    logic [15:0] satCount;
    logic [15:0] dropCount;

    int total = 0;
    int bad   = 0;
    int got[$];

    fir_output_formatter dut (
        .clk(clk), .rst(rst), .inValid(inValid), .dataIn(dataIn),
        .decimFactor(decimFactor), .outValid(outValid), .outReady(outReady),
        .dataOut(dataOut), .fifoFull(fifoFull), .satCount(satCount),
        .dropCount(dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops happen at the next rising edge; sample well after the stimulus settles.
    always @(negedge clk) begin
        #2;
        if (outValid && outReady) got.push_back(int'($signed(dataOut)));
    end

    typedef struct {
        string  name;
        longint din;
        int     exp;
        bit     clip;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Back-to-back samples k*2^20; outReady raised when sample ready_at is driven.
    task automatic stream(input int first, input int last, input int ready_at);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            if (k == ready_at) begin
                chk("full_before_pop", fifoFull, 1);
                outReady = 1'b1;
            end
            inValid = 1'b1;
            dataIn  = 38'(longint'(k) * 1048576);
        end
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic chk_got(input string name, input int exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < got.size()) ? got[i] : -99999, exp[i]);
    endtask

    initial begin
        int sat_exp;
        tbl[0] = '{"rnd_3p5",      64'sd3670016,      4,      1'b0};
        tbl[1] = '{"rnd_m3p5",    -64'sd3670016,     -3,      1'b0};
        tbl[2] = '{"rnd_1m",       64'sd1048575,      1,      1'b0};
        tbl[3] = '{"rnd_mhalf",   -64'sd524288,       0,      1'b0};
        tbl[4] = '{"rnd_mhalf1",  -64'sd524289,      -1,      1'b0};
        tbl[5] = '{"max_exact",    64'sd34358689792,  32767,  1'b0};
        tbl[6] = '{"max_rnd_up",   64'sd34359214080,  32767,  1'b1};
        tbl[7] = '{"sat_pos",      64'sd68719476736,  32767,  1'b1};
        tbl[8] = '{"sat_neg",     -64'sd137438953472, -32768, 1'b1};

        rst = 1'b1; inValid = 1'b0; dataIn = '0; decimFactor = 4'd1; outReady = 1'b1;
        #3;
        chk("rst_outValid", outValid, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_fifoFull", fifoFull, 0);
        chk("rst_satCount", satCount, 0);
        chk("rst_dropCount", dropCount, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        sat_exp = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            inValid = 1'b1;
            dataIn  = tbl[i].din[37:0];
            @(negedge clk);
            inValid = 1'b0;
            chk({tbl[i].name, "_early"}, outValid, 0);
            @(negedge clk);
            chk({tbl[i].name, "_valid"}, outValid, 1);
            chk(tbl[i].name, $signed(dataOut), tbl[i].exp);
            if (tbl[i].clip) sat_exp++;
        end
        @(negedge clk);
        chk("satCount_table", satCount, sat_exp);
        chk("drain_after_table", outValid, 0);

        decimFactor = 4'd3;
        got.delete();
        stream(1, 9, 0);
        repeat (6) @(negedge clk);
        chk_got("decim3", '{1, 4, 7});

        decimFactor = 4'd0;
        got.delete();
        stream(1, 4, 0);
        repeat (6) @(negedge clk);
        chk_got("decim0", '{1, 2, 3, 4});
        chk("satCount_decim", satCount, sat_exp);

        decimFactor = 4'd1;
        outReady = 1'b0;
        stream(1, 6, 0);
        repeat (2) @(negedge clk);
        chk("bp_full", fifoFull, 1);
        chk("bp_drop", dropCount, 2);
        chk("bp_hold_valid", outValid, 1);
        chk("bp_hold_data", $signed(dataOut), 1);
        @(negedge clk);
        chk("bp_stable_data", $signed(dataOut), 1);
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_valid", outValid, 1);
            chk("bp_drain_data", $signed(dataOut), i);
            @(negedge clk);
        end
        chk("bp_empty_valid", outValid, 0);
        chk("bp_empty_full", fifoFull, 0);

        outReady = 1'b0;
        got.delete();
        stream(1, 12, 6);
        repeat (10) @(negedge clk);
        chk_got("full_pop", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12});
        chk("full_pop_drop", dropCount, 2);
        chk("full_pop_empty", fifoFull, 0);

        outReady = 1'b0;
        stream(1, 2, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", outValid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_outValid", outValid, 0);
        chk("mid_rst_dataOut", dataOut, 0);
        chk("mid_rst_fifoFull", fifoFull, 0);
        chk("mid_rst_satCount", satCount, 0);
        chk("mid_rst_dropCount", dropCount, 0);
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_idle", outValid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
